int_mac_array_pe: RTL



---
 rtl/int_mac_array_pe_if.sv | 21 ++
 rtl/int_mac_array_pe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/int_mac_array_pe_if.sv
// Operand/result stream bundle for int_mac_array_pe: operand beats in, accumulated results out.
interface int_mac_array_pe_if #(
  parameter int W_IN_A = 8,
  parameter int W_IN_B = 16,
  parameter int LANES  = 4,
  parameter int W_ACC  = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*W_IN_A-1:0] in_a;
  logic [LANES*W_IN_B-1:0] in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [W_ACC-1:0]        out_x;
  logic                    out_ovf;

  modport master (output in_valid, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_x, out_ovf);
  modport slave  (input  in_valid, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_x, out_ovf);
endinterface

// File: rtl/int_mac_array_pe.sv
// Multi-lane integer MAC PE: per-beat dot product over LANES, accumulated over cfg_len beats.
// Optional macro INT_MAC_PE_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module int_mac_lane #(
  parameter int W_IN_A = 8,
  parameter int W_IN_B = 16
) (
  input  logic                     sgn,
  input  logic [W_IN_A-1:0]        a,
  input  logic [W_IN_B-1:0]        b,
  output logic [W_IN_A+W_IN_B-1:0] p
);
  localparam int W_P = W_IN_A + W_IN_B;
  logic [W_P-1:0] a_x, b_x;

  // Low W_P bits of the extended product are exact for both signed and unsigned operands
  always_comb begin
    a_x = {{W_IN_B{sgn & a[W_IN_A-1]}}, a};
    b_x = {{W_IN_A{sgn & b[W_IN_B-1]}}, b};
    p   = a_x * b_x;
  end
endmodule

module int_mac_array_pe #(
  parameter int W_IN_A = 8,
  parameter int W_IN_B = 16,
  parameter int LANES  = 4,
  parameter int W_ACC  = 32,
  parameter int W_LEN  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cfg_signed,
  input  logic [W_LEN-1:0] cfg_len,
  int_mac_array_pe_if.slave bus
);
  localparam int W_P = W_IN_A + W_IN_B;
  localparam int W_E = W_ACC + 1;

  logic                        stall, hs, take, first, last;
  logic                        eff_signed;
  logic [W_LEN-1:0]            eff_len, len_m1;
  logic [W_LEN-1:0]            beat_cnt, len_q;
  logic                        signed_q;

  logic [LANES-1:0][W_P-1:0]   prod_d, prod_q;
  logic                        s1_valid, s1_first, s1_last, s1_signed;

  logic                        s2_fire;
  logic [W_E-1:0]              sum, base, nxt;
  logic                        step_ovf, ovf_nxt;
  logic [W_ACC-1:0]            acc, acc_nxt;
  logic                        ovf_q;

  logic                        out_valid_q, out_ovf_q;
  logic [W_ACC-1:0]            out_x_q;

  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~rst & ~stall;
  assign hs           = bus.in_valid & bus.in_ready;
  assign take         = hs & ~clr;

  // The first beat of a block uses live config; later beats use the latched copy
  assign first      = (beat_cnt == '0);
  assign eff_signed = first ? cfg_signed : signed_q;
  assign eff_len    = first ? cfg_len    : len_q;
  assign len_m1     = (eff_len == '0) ? '0 : eff_len - W_LEN'(1);
  assign last       = (beat_cnt == len_m1);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    int_mac_lane #(.W_IN_A(W_IN_A), .W_IN_B(W_IN_B)) u_lane (
      .sgn (eff_signed),
      .a   (bus.in_a[i*W_IN_A +: W_IN_A]),
      .b   (bus.in_b[i*W_IN_B +: W_IN_B]),
      .p   (prod_d[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      len_q    <= '0;
      signed_q <= 1'b0;
    end else if (clr) begin
      beat_cnt <= '0;
    end else if (take) begin
      if (first) begin
        len_q    <= cfg_len;
        signed_q <= cfg_signed;
      end
      beat_cnt <= last ? '0 : beat_cnt + W_LEN'(1);
    end
  end

  // S1: registered lane products
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_signed <= 1'b0;
      prod_q    <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= take;
      if (take) begin
        prod_q    <= prod_d;
        s1_first  <= first;
        s1_last   <= last;
        s1_signed <= eff_signed;
      end
    end
  end

  // S2: reduce lanes and accumulate at W_ACC+1 bits so overflow is visible
  assign s2_fire = s1_valid & ~stall & ~clr;

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++)
      sum = sum + {{(W_E-W_P){s1_signed & prod_q[i][W_P-1]}}, prod_q[i]};
    base     = s1_first ? '0 : {s1_signed & acc[W_ACC-1], acc};
    nxt      = base + sum;
    step_ovf = s1_signed ? (nxt[W_ACC] ^ nxt[W_ACC-1]) : nxt[W_ACC];
    ovf_nxt  = (~s1_first & ovf_q) | step_ovf;
    acc_nxt  = nxt[W_ACC-1:0];
`ifdef INT_MAC_PE_SAT_EN
    if (step_ovf) begin
      if (!s1_signed)      acc_nxt = '1;
      else if (nxt[W_ACC]) acc_nxt = {1'b1, {(W_ACC-1){1'b0}}};
      else                 acc_nxt = {1'b0, {(W_ACC-1){1'b1}}};
    end
`else
    // wrap: truncation above already yields the modulo-2^W_ACC value
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (s2_fire) begin
      acc   <= acc_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  // A pending result survives clr; a new result may load on the consuming edge
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else if (s2_fire && s1_last) begin
      out_valid_q <= 1'b1;
      out_x_q     <= acc_nxt;
      out_ovf_q   <= ovf_nxt;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule
